uart_tx_fifo: RTL and testbench

UART transmit path: accepts bytes from the I/O controller over a `tx_en` strobe interface, buffers them in a small FIFO, and serializes them as 8N1 frames on the `tx` line. The FIFO absorbs bursts such as a 15-byte greeting string issued on consecutive cycles. `tx_rdy` provides the flow-control handshake back to the controller.

---
 rtl/uart_tx_fifo.sv | 146 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter behind a 2^DEPTH_LOG2-entry byte FIFO; start bit begins one edge after the push.
// tx_rdy drops while the FIFO is full; a push attempted then is dropped and latches the sticky overflow flag.
module uart_tx_fifo #(
    parameter int DIV        = 434,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       tx_en,
    output logic       tx_rdy,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [15:0] BAUD_MAX = 16'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic [1:0]            state_q, state_d;
    logic [7:0]            shift_q, shift_d;
    logic [15:0]           baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic                  tx_q, tx_d;
    logic                  ovf_q, ovf_d;
    logic                  push, pop, fifo_nempty, baud_end;

    assign tx_rdy      = (cnt_q != CNT_FULL);
    assign push        = tx_en && tx_rdy;
    assign fifo_nempty = (cnt_q != '0);
    assign baud_end    = (baud_q == BAUD_MAX);

    assign tx       = tx_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != S_IDLE) || fifo_nempty;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (state_q != S_IDLE) begin
            baud_d = baud_end ? 16'd0 : baud_q + 16'd1;
        end
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    tx_d    = 1'b0;
                    baud_d  = 16'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Chain straight into the next start bit so queued bytes leave without an idle gap.
                if (baud_end) begin
                    if (fifo_nempty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q || (tx_en && !tx_rdy);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
            shift_q <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (DIV 4, 8, 1) with a frame-decoding monitor feeding a byte scoreboard.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       en4, en8, en1;
    logic       rdy4, tx4, busy4, ovf4;
    logic       rdy8, tx8, busy8, ovf8;
    logic       rdy1, tx1, busy1, ovf1;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DIV(4), .DEPTH_LOG2(4)) u_div4 (
        .clk(clk), .rst(rst), .din(din), .tx_en(en4),
        .tx_rdy(rdy4), .tx(tx4), .busy(busy4), .overflow(ovf4)
    );
    uart_tx_fifo #(.DIV(8), .DEPTH_LOG2(4)) u_div8 (
        .clk(clk), .rst(rst), .din(din), .tx_en(en8),
        .tx_rdy(rdy8), .tx(tx8), .busy(busy8), .overflow(ovf8)
    );
    uart_tx_fifo #(.DIV(1), .DEPTH_LOG2(4)) u_div1 (
        .clk(clk), .rst(rst), .din(din), .tx_en(en1),
        .tx_rdy(rdy1), .tx(tx1), .busy(busy1), .overflow(ovf1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic sel_busy(input int w);
        case (w)
            1:       return busy8;
            2:       return busy1;
            default: return busy4;
        endcase
    endfunction

    task automatic wait_idle(input int w, input int budget, input string name);
        int k;
        k = 0;
        while (sel_busy(w) !== 1'b0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, 32'(k < budget), 1);
    endtask

    // Scoreboard of bytes the DUT is expected to serialize, in order.
    logic [7:0] sb_q[$];

    int         mon_sel = 0;
    int         mon_div = 4;
    bit         mon_en = 1'b0;
    int         test_id = 0;
    int         mon_test = 0;
    int         mon_nframes = 0;
    int         mon_last_t = 0;
    int         mon_t0;
    logic [7:0] mon_b;
    logic [7:0] mon_exp;
    logic       mon_prev = 1'b1;
    logic       mon_line;

    assign mon_line = (mon_sel == 1) ? tx8 : (mon_sel == 2) ? tx1 : tx4;

    initial forever begin
        @(negedge clk);
        if (mon_en && mon_prev === 1'b1 && mon_line === 1'b0) begin
            if (mon_test != test_id) begin
                mon_test    = test_id;
                mon_nframes = 0;
            end
            mon_t0 = cyc;
            if (mon_nframes > 0) check("frame_spacing", mon_t0 - mon_last_t, 10 * mon_div);
            for (int i = 0; i < 8; i++) begin
                repeat (mon_div) @(negedge clk);
                mon_b[i] = mon_line;
            end
            repeat (mon_div) @(negedge clk);
            check("stop_bit", 32'(mon_line), 1);
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_frame: got %0h expected no frame", mon_b);
            end else begin
                mon_exp = sb_q.pop_front();
                check("frame_byte", 32'(mon_b), 32'(mon_exp));
            end
            mon_nframes++;
            mon_last_t = mon_t0;
        end
        mon_prev = mon_line;
    end

    typedef struct {
        logic       en;
        logic [7:0] din;
        logic       tx;
        logic       busy;
        logic       rdy;
    } vec_t;

    vec_t       vecs[23];
    logic [7:0] hello[15];
    logic [7:0] byte48;
    logic       e;
    int         bad;

    initial begin
        rst = 1'b0; din = 8'h00; en4 = 1'b0; en8 = 1'b0; en1 = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_tx", 32'(tx4), 1);
        check("rst_rdy", 32'(rdy4), 1);
        check("rst_busy", 32'(busy4), 0);
        check("rst_ovf", 32'(ovf4), 0);
        check("rst_tx8_tx1", 32'({tx8, tx1}), 3);
        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (tx4 !== 1'b1 || tx8 !== 1'b1 || tx1 !== 1'b1) bad++;
        end
        check("idle_tx_high", bad, 0);

        // Single byte, DIV=4
        test_id = 1; mon_sel = 0; mon_div = 4; mon_en = 1'b1;
        byte48 = 8'h48;
        din = 8'h48; en4 = 1'b1; sb_q.push_back(8'h48);
        @(posedge clk); #1;
        en4 = 1'b0;
        check("sb_e0_tx", 32'(tx4), 1);
        check("sb_e0_busy", 32'(busy4), 1);
        for (int k = 1; k <= 41; k++) begin
            @(posedge clk); #1;
            if (k <= 4) e = 1'b0;
            else if (k <= 36) e = byte48[(k - 5) / 4];
            else e = 1'b1;
            check($sformatf("sb_tx_%0d", k), 32'(tx4), 32'(e));
            if (k == 40) check("sb_busy_e40", 32'(busy4), 1);
            if (k == 41) check("sb_busy_e41", 32'(busy4), 0);
        end
        repeat (5) @(posedge clk);
        #1;

        // 15-byte burst, DIV=4
        test_id = 2;
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h77,
                  8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};
        for (int i = 0; i < 15; i++) begin
            din = hello[i]; en4 = 1'b1; sb_q.push_back(hello[i]);
            @(posedge clk); #1;
        end
        en4 = 1'b0;
        wait_idle(0, 700, "burst_done");
        repeat (3) @(posedge clk);
        #1;
        check("burst_frames", mon_nframes, 15);
        check("burst_sb_empty", sb_q.size(), 0);
        check("burst_no_ovf", 32'(ovf4), 0);

        // Overflow, DIV=8: 18 pushes, the last one is dropped
        test_id = 3; mon_sel = 1; mon_div = 8;
        for (int i = 0; i < 18; i++) begin
            din = 8'(i * 7 + 3); en8 = 1'b1;
            if (i < 17) sb_q.push_back(8'(i * 7 + 3));
            @(posedge clk); #1;
            if (i == 15) check("ovf_rdy_before_full", 32'(rdy8), 1);
            if (i == 16) begin
                check("ovf_rdy_full", 32'(rdy8), 0);
                check("ovf_not_yet", 32'(ovf8), 0);
            end
            if (i == 17) check("ovf_set", 32'(ovf8), 1);
        end
        en8 = 1'b0;
        wait_idle(1, 17 * 80 + 100, "ovf_done");
        repeat (3) @(posedge clk);
        #1;
        check("ovf_frames", mon_nframes, 17);
        check("ovf_sb_empty", sb_q.size(), 0);
        check("ovf_sticky", 32'(ovf8), 1);

        // Reset mid-frame, DIV=4
        test_id = 4; mon_en = 1'b0; mon_sel = 0; mon_div = 4;
        din = 8'hA5; en4 = 1'b1;
        @(posedge clk); #1;
        din = 8'h3C;
        @(posedge clk); #1;
        en4 = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check("mid_bit3", 32'(tx4), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_tx", 32'(tx4), 1);
        check("mid_rst_busy", 32'(busy4), 0);
        check("mid_rst_rdy", 32'(rdy4), 1);
        check("mid_rst_ovf8_clear", 32'(ovf8), 0);
        rst = 1'b1;
        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (tx4 !== 1'b1 || busy4 !== 1'b0) bad++;
        end
        check("mid_no_frames", bad, 0);

        // Degenerate divider, DIV=1: per-cycle vector table
        test_id = 5; mon_sel = 2; mon_div = 1; mon_en = 1'b1;
        vecs = '{
            '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1}, '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1}, '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1}, '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1}, '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1}, '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1}, '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1}, '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1}, '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1}, '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1}, '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1}, '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1}
        };
        for (int k = 0; k < 23; k++) begin
            en1 = vecs[k].en; din = vecs[k].din;
            if (vecs[k].en) sb_q.push_back(vecs[k].din);
            @(posedge clk); #1;
            check($sformatf("div1_tx_%0d", k), 32'(tx1), 32'(vecs[k].tx));
            check($sformatf("div1_busy_%0d", k), 32'(busy1), 32'(vecs[k].busy));
            check($sformatf("div1_rdy_%0d", k), 32'(rdy1), 32'(vecs[k].rdy));
        end
        en1 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("div1_frames", mon_nframes, 2);
        check("div1_sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
